// File: rtl/gv_input_pkg.sv
// Shared defaults and helpers for the button input front end.
// Debounce defaults give 10 ms at a 12 MHz clock.
package gv_input_pkg;

  localparam int NBTN       = 4;
  localparam int DEB_CYCLES = 120000;
  localparam int CNT_W      = 17;

  typedef logic [NBTN-1:0] btn_mask_t;

  // Saturating 8-bit accumulate, used for the lost-press counter.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// One button channel: two-flop synchroniser, disagreement counter,
// accepted level and single-cycle press/release strobes.
module btn_debounce #(
  parameter int DEB_CYCLES = 120000,
  parameter int CNT_W      = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic held,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      cnt           <= '0;
      held          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= raw;
      s2            <= s1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (s2 == held) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        // Level accepted: strobes line up with the first cycle of the new level.
        held          <= s2;
        cnt           <= '0;
        press_pulse   <= s2;
        release_pulse <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Button front end: per-lane debounce plus a press-event channel
// that merges presses until the game core accepts them.
module button_conditioner #(
  parameter int NBTN       = gv_input_pkg::NBTN,
  parameter int DEB_CYCLES = gv_input_pkg::DEB_CYCLES,
  parameter int CNT_W      = gv_input_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] held,
  output logic [NBTN-1:0] press_pulse,
  output logic [NBTN-1:0] release_pulse,
  output logic            evt_valid,
  output logic [NBTN-1:0] evt_code,
  input  logic            evt_ready,
  output logic [7:0]      drop_cnt
);

  import gv_input_pkg::*;

  logic [NBTN-1:0] pend;
  logic [NBTN-1:0] pend_next;
  logic [NBTN-1:0] lost;
  logic [7:0]      lost_n;
  logic            accept;

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk           (clk),
      .rst           (rst),
      .raw           (btn_raw[i]),
      .held          (held[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

  assign evt_code  = pend;
  assign evt_valid = |pend;
  assign accept    = evt_valid & evt_ready;

  // A press arriving on the accept edge is kept for the next event.
  always_comb begin
    pend_next = (pend & ~(accept ? pend : '0)) | press_pulse;
    lost      = press_pulse & pend & {NBTN{~accept}};
    lost_n    = '0;
    for (int i = 0; i < NBTN; i++) begin
      lost_n = lost_n + 8'(lost[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      drop_cnt <= '0;
    end else begin
      pend     <= pend_next;
      drop_cnt <= sat_add8(drop_cnt, lost_n);
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a short debounce window.
module tb_button_conditioner;
  import gv_input_pkg::*;

  localparam int NB  = 4;
  localparam int DEB = 4;
  localparam int CW  = 3;

  logic            clk;
  logic            rst;
  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   held;
  logic [NB-1:0]   press_pulse;
  logic [NB-1:0]   release_pulse;
  logic            evt_valid;
  logic [NB-1:0]   evt_code;
  logic            evt_ready;
  logic [7:0]      drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  button_conditioner #(
    .NBTN       (NB),
    .DEB_CYCLES (DEB),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .held          (held),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .evt_valid     (evt_valid),
    .evt_code      (evt_code),
    .evt_ready     (evt_ready),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    btn_mask_t m;
    rst       = 1'b1;
    btn_raw   = 4'hF;
    evt_ready = 1'b0;

    // Reset with all buttons held, then re-registration
    tick(2);
    chk("rst_held", held, 4'h0);
    chk("rst_press", press_pulse, 4'h0);
    chk("rst_release", release_pulse, 4'h0);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_code", evt_code, 4'h0);
    chk("rst_drop", drop_cnt, 8'd0);
    rst = 1'b0;
    tick(5);
    chk("rst_held_e5", held, 4'h0);
    tick(1);
    chk("rst_held_e6", held, 4'hF);
    chk("rst_press_e6", press_pulse, 4'hF);
    tick(1);
    chk("rst_press_e7", press_pulse, 4'h0);
    chk("rst_code_e7", evt_code, 4'hF);
    chk("rst_valid_e7", evt_valid, 1'b1);
    evt_ready = 1'b1;
    tick(1);
    chk("rst_accept", evt_valid, 1'b0);
    evt_ready = 1'b0;

    // Release everything
    btn_raw = 4'h0;
    tick(5);
    chk("relall_e5", release_pulse, 4'h0);
    tick(1);
    chk("relall_e6", release_pulse, 4'hF);
    chk("relall_held", held, 4'h0);
    tick(1);
    chk("relall_code", evt_code, 4'h0);

    // Clean step on btn0
    btn_raw = 4'b0001;
    tick(5);
    chk("step_held_e5", held, 4'h0);
    tick(1);
    chk("step_held_e6", held, 4'b0001);
    chk("step_press_e6", press_pulse, 4'b0001);
    tick(1);
    chk("step_press_e7", press_pulse, 4'h0);
    chk("step_code", evt_code, 4'b0001);
    chk("step_valid", evt_valid, 1'b1);

    // Handshake: add btn2 while not ready, chord merges
    btn_raw = 4'b0101;
    tick(6);
    chk("hs_press2", press_pulse, 4'b0100);
    tick(1);
    chk("hs_code", evt_code, 4'b0101);
    chk("hs_drop", drop_cnt, 8'd0);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("hs_valid_after", evt_valid, 1'b0);
    chk("hs_code_after", evt_code, 4'h0);

    // Overflow: btn0 pending, three more presses are lost
    btn_raw = 4'h0;
    tick(7);
    btn_raw = 4'b0001;
    tick(7);
    chk("ov_pend", evt_code, 4'b0001);
    for (int k = 1; k <= 3; k++) begin
      btn_raw = 4'h0;
      tick(6);
      btn_raw = 4'b0001;
      tick(7);
      chk("ov_drop", drop_cnt, 8'(k));
    end
    chk("ov_code", evt_code, 4'b0001);

    // Press landing on the accept edge survives, no drop
    btn_raw = 4'h0;
    tick(6);
    btn_raw = 4'b0001;
    tick(6);
    chk("acc_press", press_pulse, 4'b0001);
    evt_ready = 1'b1;
    tick(1);
    chk("acc_code", evt_code, 4'b0001);
    chk("acc_valid", evt_valid, 1'b1);
    chk("acc_drop", drop_cnt, 8'd3);
    tick(1);
    evt_ready = 1'b0;
    chk("acc_clear", evt_valid, 1'b0);

    // Bounce on btn1: 10 alternating cycles, then settle high
    for (int i = 0; i < 10; i++) begin
      m       = btn_raw;
      m[1]    = ((i % 2) == 0);
      btn_raw = m;
      tick(1);
      chk("bnc_nopulse", press_pulse[1], 1'b0);
    end
    btn_raw = 4'b0011;
    tick(5);
    chk("bnc_e5_press", press_pulse[1], 1'b0);
    chk("bnc_e5_held", held[1], 1'b0);
    tick(1);
    chk("bnc_e6_press", press_pulse, 4'b0010);
    tick(1);
    chk("bnc_code", evt_code, 4'b0010);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;

    // Release of btn3 leaves the pending event untouched
    btn_raw = 4'b1011;
    tick(6);
    chk("rel_press3", press_pulse, 4'b1000);
    tick(1);
    chk("rel_code_pre", evt_code, 4'b1000);
    btn_raw = 4'b0011;
    tick(5);
    chk("rel_e5", release_pulse, 4'h0);
    tick(1);
    chk("rel_e6", release_pulse, 4'b1000);
    chk("rel_held", held, 4'b0011);
    tick(1);
    chk("rel_e7", release_pulse, 4'h0);
    chk("rel_code", evt_code, 4'b1000);

    // Reset in the middle of a debounce
    btn_raw = 4'b0111;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_held", held, 4'h0);
    chk("mid_code", evt_code, 4'h0);
    chk("mid_drop", drop_cnt, 8'd0);
    tick(5);
    chk("mid_e5", held, 4'h0);
    tick(1);
    chk("mid_e6_held", held, 4'b0111);
    chk("mid_e6_press", press_pulse, 4'b0111);
    tick(1);
    chk("mid_code_e7", evt_code, 4'b0111);

    // Saturation of drop_cnt
    for (int k = 0; k < 255; k++) begin
      btn_raw = 4'b0110;
      tick(6);
      btn_raw = 4'b0111;
      tick(7);
    end
    chk("sat_255", drop_cnt, 8'd255);
    btn_raw = 4'b0110;
    tick(6);
    btn_raw = 4'b0111;
    tick(7);
    chk("sat_hold", drop_cnt, 8'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
